// File: rtl/reset_seq_ctrl_pkg.sv
// Shared constants for the sequenced reset controller.
// Latency: n/a (constants and an elaboration-time helper only).
// Backpressure: n/a.
//
// Holds the FSM state encodings, the reset-cause codes, the default
// parameter values and a width-check helper used by the generate-time guards.
package reset_seq_ctrl_pkg;

   // FSM state encodings
   localparam logic [1:0] ST_HOLD = 2'd0;
   localparam logic [1:0] ST_STEP = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   // reset_cause codes (2'd3 is never produced)
   localparam logic [1:0] RST_CAUSE_POR = 2'd0;
   localparam logic [1:0] RST_CAUSE_EXT = 2'd1;
   localparam logic [1:0] RST_CAUSE_SW  = 2'd2;

   // Default parameter values
   localparam int DEF_N_DOM    = 3;
   localparam int DEF_HOLD_CYC = 8;
   localparam int DEF_STEP_CYC = 4;
   localparam int DEF_DEB_CYC  = 16;
   localparam int DEF_CNT_W    = 8;
   localparam int DEF_DEB_W    = 5;

   // True when an unsigned counter of width w can represent val.
   function automatic bit fits_width(input int unsigned val, input int unsigned w);
      return (64'(val) >> w) == 64'd0;
   endfunction

endpackage

// File: rtl/reset_debounce.sv
// Debounces the raw external reset button into a clean active-low level.
// Latency: 2 sync flops + DEB_CYC stable cycles before level_n/fall_pulse move.
// Backpressure: none; free-running, output is a level plus a one-cycle pulse.
//
// Ports:
//   clk        - system clock
//   reset      - asynchronous active-low reset
//   raw_n      - raw, asynchronous, bouncing button input (active-low)
//   level_n    - debounced level, resets to 1 (released)
//   fall_pulse - one-cycle pulse, registered together with level_n falling
module reset_debounce
   import reset_seq_ctrl_pkg::*;
#(
   parameter int DEB_CYC = DEF_DEB_CYC,
   parameter int DEB_W   = DEF_DEB_W
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_n,
   output logic level_n,
   output logic fall_pulse
);

   if (DEB_CYC < 2 || !fits_width(DEB_CYC, DEB_W)) begin : g_bad_deb_param
      $error("reset_debounce: DEB_CYC must be >= 2 and fit in DEB_W bits");
   end

   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             fall_q;
   logic [DEB_W-1:0] cnt_q;

   // The sync flops clear to 0 while the level clears to 1, so the first two
   // cycles after reset count as a mismatch; that count is far below DEB_LAST
   // and is wiped as soon as the real (high) button value arrives.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_n;
         sync2_q <= sync1_q;
         fall_q  <= 1'b0;
         if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == DEB_LAST) begin
            // DEB_CYC consecutive mismatching samples: accept the new level
            level_q <= sync2_q;
            fall_q  <= ~sync2_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign level_n    = level_q;
   assign fall_pulse = fall_q;

endmodule

// File: rtl/reset_seq_ctrl.sv
// Sequenced multi-domain reset generator: all domains assert together, release in order.
// Latency: HOLD_CYC cycles after the source clears to domain 0, then STEP_CYC per domain.
// Backpressure: none; requests act on the next edge and restart the sequence.
//
// Ports:
//   clk          - system clock
//   reset        - asynchronous active-low board/power-on reset
//   ext_reset_n  - raw bouncing external reset button (active-low)
//   sw_reset_req - single-cycle synchronous software/watchdog reset request
//   rst_n_out    - per-domain active-low resets, bit 0 released first
//   reset_done   - high once every domain is released
//   reset_cause  - cause of the last reset (POR/EXT/SW)
module reset_seq_ctrl
   import reset_seq_ctrl_pkg::*;
#(
   parameter int N_DOM    = DEF_N_DOM,
   parameter int HOLD_CYC = DEF_HOLD_CYC,
   parameter int STEP_CYC = DEF_STEP_CYC,
   parameter int DEB_CYC  = DEF_DEB_CYC,
   parameter int CNT_W    = DEF_CNT_W,
   parameter int DEB_W    = DEF_DEB_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ext_reset_n,
   input  logic             sw_reset_req,
   output logic [N_DOM-1:0] rst_n_out,
   output logic             reset_done,
   output logic [1:0]       reset_cause
);

   if (N_DOM < 1 || N_DOM > 8) begin : g_bad_n_dom
      $error("reset_seq_ctrl: N_DOM must be in 1..8");
   end
   if (HOLD_CYC < 1 || STEP_CYC < 1) begin : g_bad_cyc
      $error("reset_seq_ctrl: HOLD_CYC and STEP_CYC must be >= 1");
   end
   if (!fits_width(HOLD_CYC, CNT_W) || !fits_width(STEP_CYC, CNT_W)) begin : g_bad_cnt_w
      $error("reset_seq_ctrl: CNT_W too narrow for max(HOLD_CYC, STEP_CYC)");
   end

   localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOM - 1);

   logic             rst_s1_q;
   logic             rst_sync;
   logic             ext_level_n;
   logic             ext_fall;
   logic [1:0]       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_nxt;
   logic [N_DOM-1:0] rst_n_q;
   logic             done_q;
   logic [1:0]       cause_q;
   logic             sw_req_eff;

   // Reset release is synchronised so the first FSM step sees a clean edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_s1_q <= 1'b0;
         rst_sync <= 1'b0;
      end else begin
         rst_s1_q <= 1'b1;
         rst_sync <= rst_s1_q;
      end
   end

   reset_debounce #(
      .DEB_CYC (DEB_CYC),
      .DEB_W   (DEB_W)
   ) u_debounce (
      .clk        (clk),
      .reset      (reset),
      .raw_n      (ext_reset_n),
      .level_n    (ext_level_n),
      .fall_pulse (ext_fall)
   );

   // A software pulse while the button is held down would only repeat a reset
   // already in force, so it neither restarts anything nor changes the cause.
   assign sw_req_eff = sw_reset_req & ext_level_n;
   assign idx_nxt    = idx_q + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_HOLD;
         cnt_q   <= '0;
         idx_q   <= '0;
         rst_n_q <= '0;
         done_q  <= 1'b0;
         cause_q <= RST_CAUSE_POR;
      end else if (rst_sync) begin
         if (ext_fall || sw_req_eff) begin
            // EXT wins when both arrive together
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
            cause_q <= ext_fall ? RST_CAUSE_EXT : RST_CAUSE_SW;
         end else if (!ext_level_n) begin
            // Button still held: park in HOLD with the counter frozen at 0
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_HOLD: begin
                  if (cnt_q == HOLD_LAST) begin
                     cnt_q <= '0;
                     idx_q <= '0;
                     if (N_DOM == 1) begin
                        state_q <= ST_RUN;
                        rst_n_q <= '1;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= ST_STEP;
                        rst_n_q <= N_DOM'(1);
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               ST_STEP: begin
                  if (cnt_q == STEP_LAST) begin
                     cnt_q   <= '0;
                     idx_q   <= idx_nxt;
                     rst_n_q <= rst_n_q | (N_DOM'(1) << idx_nxt);
                     if (idx_nxt == IDX_LAST) begin
                        state_q <= ST_RUN;
                        done_q  <= 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               ST_RUN: begin
                  state_q <= ST_RUN;
               end
               default: begin
                  state_q <= ST_HOLD;
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  rst_n_q <= '0;
                  done_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign rst_n_out   = rst_n_q;
   assign reset_done  = done_q;
   assign reset_cause = cause_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl with default parameters (3 domains, 8/4 spacing).
// Latency: n/a.
// Backpressure: n/a.
module tb_reset_seq_ctrl;

   logic       clk;
   logic       reset;
   logic       ext_reset_n;
   logic       sw_reset_req;
   logic [2:0] rst_n_out;
   logic       reset_done;
   logic [1:0] reset_cause;

   int n_checks;
   int n_fail;

   reset_seq_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .ext_reset_n  (ext_reset_n),
      .sw_reset_req (sw_reset_req),
      .rst_n_out    (rst_n_out),
      .reset_done   (reset_done),
      .reset_cause  (reset_cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, then sample 1 ns later
   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic [2:0] exp_out,
                             input logic exp_done, input logic [1:0] exp_cause);
      check_val({tag, "_out"}, 32'(rst_n_out), 32'(exp_out));
      check_val({tag, "_done"}, 32'(reset_done), 32'(exp_done));
      check_val({tag, "_cause"}, 32'(reset_cause), 32'(exp_cause));
   endtask

   // Caller raises reset between edges; edge 1 is the next rising edge.
   // Releases expected after edges 10, 14 and 18.
   task automatic por_sequence(input string tag);
      wait_edges(9);
      check_outs({tag, "_e9"}, 3'b000, 1'b0, 2'd0);
      wait_edges(1);
      check_outs({tag, "_e10"}, 3'b001, 1'b0, 2'd0);
      wait_edges(3);
      check_val({tag, "_e13_out"}, 32'(rst_n_out), 32'h1);
      wait_edges(1);
      check_outs({tag, "_e14"}, 3'b011, 1'b0, 2'd0);
      wait_edges(3);
      check_outs({tag, "_e17"}, 3'b011, 1'b0, 2'd0);
      wait_edges(1);
      check_outs({tag, "_e18"}, 3'b111, 1'b1, 2'd0);
   endtask

   // Called right after the edge where HOLD restarts (outputs just cleared):
   // releases follow 8, 12 and 16 edges later.
   task automatic restart_sequence(input string tag, input logic [1:0] cause);
      wait_edges(7);
      check_outs({tag, "_h7"}, 3'b000, 1'b0, cause);
      wait_edges(1);
      check_outs({tag, "_h8"}, 3'b001, 1'b0, cause);
      wait_edges(4);
      check_outs({tag, "_h12"}, 3'b011, 1'b0, cause);
      wait_edges(4);
      check_outs({tag, "_h16"}, 3'b111, 1'b1, cause);
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      reset        = 1'b0;
      ext_reset_n  = 1'b1;
      sw_reset_req = 1'b0;

      // Reset state
      #1;
      check_outs("rst", 3'b000, 1'b0, 2'd0);
      wait_edges(2);
      check_outs("rst_hold", 3'b000, 1'b0, 2'd0);

      // Power-on release
      reset = 1'b1;
      por_sequence("por");

      // Software request from RUN
      wait_edges(3);
      sw_reset_req = 1'b1;
      wait_edges(1);
      sw_reset_req = 1'b0;
      check_outs("sw_req", 3'b000, 1'b0, 2'd2);
      restart_sequence("sw", 2'd2);

      // Short button glitches are filtered out
      for (int g = 0; g < 3; g++) begin
         ext_reset_n = 1'b0;
         wait_edges(5);
         ext_reset_n = 1'b1;
         wait_edges(10);
      end
      check_outs("glitch", 3'b111, 1'b1, 2'd2);

      // Long button press: level falls at edge 18, FSM reacts on edge 19
      ext_reset_n = 1'b0;
      wait_edges(18);
      check_outs("ext_e18", 3'b111, 1'b1, 2'd2);
      wait_edges(1);
      check_outs("ext_e19", 3'b000, 1'b0, 2'd1);
      wait_edges(21);
      check_outs("ext_held", 3'b000, 1'b0, 2'd1);
      // Release: level rises 18 edges later, HOLD counts the next 8 edges
      ext_reset_n = 1'b1;
      wait_edges(25);
      check_outs("ext_rel25", 3'b000, 1'b0, 2'd1);
      wait_edges(1);
      check_outs("ext_rel26", 3'b001, 1'b0, 2'd1);
      wait_edges(4);
      check_outs("ext_rel30", 3'b011, 1'b0, 2'd1);
      wait_edges(4);
      check_outs("ext_rel34", 3'b111, 1'b1, 2'd1);

      // Debounced fall and software pulse on the same cycle: EXT wins
      wait_edges(2);
      ext_reset_n = 1'b0;
      wait_edges(18);
      sw_reset_req = 1'b1;
      wait_edges(1);
      sw_reset_req = 1'b0;
      ext_reset_n  = 1'b1;
      check_outs("simul", 3'b000, 1'b0, 2'd1);
      wait_edges(25);
      check_outs("simul_rel25", 3'b000, 1'b0, 2'd1);
      wait_edges(1);
      check_outs("simul_rel26", 3'b001, 1'b0, 2'd1);
      wait_edges(8);
      check_outs("simul_rel34", 3'b111, 1'b1, 2'd1);

      // Request in the middle of STEP
      wait_edges(2);
      sw_reset_req = 1'b1;
      wait_edges(1);
      sw_reset_req = 1'b0;
      wait_edges(8);
      check_outs("step_pre", 3'b001, 1'b0, 2'd2);
      sw_reset_req = 1'b1;
      wait_edges(1);
      sw_reset_req = 1'b0;
      check_outs("step_req", 3'b000, 1'b0, 2'd2);
      restart_sequence("step", 2'd2);

      // Async reset in the middle of STEP, no clock edge needed
      wait_edges(2);
      sw_reset_req = 1'b1;
      wait_edges(1);
      sw_reset_req = 1'b0;
      wait_edges(12);
      check_outs("async_pre", 3'b011, 1'b0, 2'd2);
      #2;
      reset = 1'b0;
      #1;
      check_outs("async", 3'b000, 1'b0, 2'd0);
      wait_edges(2);
      reset = 1'b1;
      por_sequence("por2");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reset_seq_ctrl.md
Name: reset_seq_ctrl

Overview:
- Parametrised successor to the single-output chip reset generator.
- Takes the board reset, a raw external reset button and a software reset request.
- Produces N_DOM active-low domain resets. All domains assert together; they release one at a time, in order, with programmable spacing.
- Reports completion and a reset-cause code. Sits beside the clock generator at chip top and feeds the CPU, bus and peripheral reset nets.

Parameters:
- N_DOM, 3: number of reset domains. Range 1..8. Bit 0 is released first.
- HOLD_CYC, 8: cycles all domains stay asserted after the reset source clears. Must be ≥1.
- STEP_CYC, 4: cycles between successive domain releases. Must be ≥1.
- DEB_CYC, 16: consecutive stable cycles required on ext_reset_n to change its debounced level. Must be ≥2.
- CNT_W, 8: width of the hold/step counter. Must hold max(HOLD_CYC, STEP_CYC).
- DEB_W, 5: width of the debounce counter. Must hold DEB_CYC.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low power-on/board reset.
- ext_reset_n, input, 1: raw, asynchronous, bouncing external reset button. Active-low.
- sw_reset_req, input, 1: synchronous single-cycle software/watchdog reset request pulse.
- rst_n_out, output, N_DOM: per-domain active-low resets, registered.
- reset_done, output, 1: high once all domains are released.
- reset_cause, output, 2: cause of the last reset. 0 = POR, 1 = EXT, 2 = SW, 3 unused.

Behaviour:
- Reset values while reset=0:
  - rst_n_out = all 0
  - reset_done = 0
  - reset_cause = 0
  - FSM = HOLD, counters = 0
  - debounced ext level = 1
  - synchroniser flops = 0
- All output flops are cleared asynchronously by reset.
- Reset release path:
  - reset deassertion passes through a 2-flop synchroniser (rst_sync); the FSM advances only when rst_sync=1.
  - Edge numbering: edge k is the k-th rising clk edge after reset rises.
  - rst_sync goes high after edge 2. HOLD counts edges 3..2+HOLD_CYC.
- FSM states:
  - HOLD: all rst_n_out=0, reset_done=0. Counter increments each cycle; at HOLD_CYC-1 the FSM goes to STEP with idx=0 and sets rst_n_out[0]=1 on that same edge.
  - STEP: domains 0..idx are released. Counter restarts at 0. When the counter reaches STEP_CYC-1: idx increments and rst_n_out[idx] is set to 1. If idx reaches N_DOM-1, the FSM goes to RUN and reset_done=1 on the same edge as the last release.
  - RUN: all outputs high, reset_done=1. Stays until a request.
  - N_DOM=1: the FSM goes HOLD→RUN directly.
- Reset requests:
  - A request is either the debounced ext level falling to 0 or sw_reset_req=1.
  - In any state, a request causes, on the next edge: rst_n_out=all 0, reset_done=0, counter=0, state=HOLD, reset_cause updated.
  - A request during HOLD/STEP restarts the full sequence.
  - While the debounced ext level remains 0, the FSM stays in HOLD with the counter held at 0. Counting starts the cycle after the debounced level returns to 1.
  - Simultaneous ext and sw request: cause = EXT.
  - An sw pulse while the ext level is held low is ignored for cause purposes.
- Debounce:
  - ext_reset_n passes through a 2-flop synchroniser.
  - A counter counts consecutive cycles where the synchronised value differs from the debounced level; any match clears it.
  - When the count reaches DEB_CYC-1, the debounced level toggles and the counter clears.
  - Glitches shorter than DEB_CYC cycles produce no request.
- reset_cause holds its value until the next request. It is reset to POR only by reset.
- Async reset mid-sequence: every flop clears immediately and the sequence restarts from POR.
- Counter width: CNT_W must hold max(HOLD_CYC, STEP_CYC). Elaboration fails via a generate-time check if not.

Decomposition:
- Shared header reset_seq.h:
  - FSM state encodings (HOLD=2'd0, STEP=2'd1, RUN=2'd2).
  - Cause codes (RST_CAUSE_POR=2'd0, RST_CAUSE_EXT=2'd1, RST_CAUSE_SW=2'd2).
  - Default parameter values.
- One sub-module, reset_debounce:
  - Parameters: DEB_CYC, DEB_W.
  - Ports: clk, reset, raw_n in; level_n out; fall_pulse out.
  - Contains the 2-flop synchroniser and the stable-count logic.
  - The top-level FSM and release shift logic stay in reset_seq_ctrl.

Test Plan:
- POR with defaults (N_DOM=3, HOLD_CYC=8, STEP_CYC=4): drop reset, then raise it → rst_n_out[0] rises after edge 10, [1] after edge 14, [2] after edge 18; reset_done=1 after edge 18; reset_cause=0.
- SW request in RUN: pulse sw_reset_req for 1 cycle → rst_n_out=3'b000 and reset_done=0 on the next edge, reset_cause=2; release sequence repeats with 8/4/4 spacing.
- Ext button with bounce: toggle ext_reset_n low for 5 cycles, 3 times → no request. Then hold low for 40 cycles → request 17–18 cycles after the stable fall, reset_cause=1, outputs held low until 16 cycles after release, then the HOLD sequence runs.
- Simultaneous ext debounced fall and sw_reset_req on the same cycle → reset_cause=1 (EXT); a single restart.
- Request during STEP (after rst_n_out=3'b001) → all outputs back to 0 on the next edge; full sequence restarts with HOLD_CYC=8.
- Async reset asserted mid-STEP → rst_n_out=0, reset_done=0 and reset_cause=0 with no clock edge; after release, timing matches the first scenario exactly.
